// File: rtl/trap_ctrl_if.sv
// Execute-stage / CSR-file bundle seen by the trap sequencer.
// master: trap_ctrl side; slave: pipeline and CSR file side.
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            ex_ecall_i;
  logic            ex_mret_i;
  logic            cpu_csr_wen_i;
  logic            global_int_en_i;
  logic            mtime_int_en_i;
  logic            mtime_int_pend_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic [XLEN-1:0] csr_mstatus_i;
  logic            clint_csr_wen_o;
  logic [11:0]     clint_csr_waddr_o;
  logic [XLEN-1:0] clint_csr_wdata_o;
  logic            stall_o;
  logic            flush_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    input  ex_valid_i, ex_pc_i, ex_ecall_i, ex_mret_i,
    input  cpu_csr_wen_i,
    input  global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output clint_csr_wen_o, clint_csr_waddr_o, clint_csr_wdata_o,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output ex_valid_i, ex_pc_i, ex_ecall_i, ex_mret_i,
    output cpu_csr_wen_i,
    output global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  clint_csr_wen_o, clint_csr_waddr_o, clint_csr_wdata_o,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap entry / mret sequencer over the shared CSR write port.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets.
module trap_ctrl #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11),
  parameter logic [XLEN-1:0] CAUSE_MTI   =
    {1'b1, {(XLEN-4){1'b0}}, 3'd7}
) (
  input  logic         clk,
  input  logic         rst_n,
  trap_ctrl_if.master  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    MRET_MST,
    JUMP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mret_q, mret_d;

  logic            irq;
  logic            busy_cpu;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mst_trap;
  logic [XLEN-1:0] mst_mret;

  assign irq = bus.global_int_en_i
             & bus.mtime_int_en_i
             & bus.mtime_int_pend_i;
  assign busy_cpu = bus.cpu_csr_wen_i;
  assign base = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_tgt =
    (bus.csr_mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
      ? base + XLEN'({cause_q[5:0], 2'b00})
      : base;
`else
  logic unused_mode;
  assign unused_mode = ^bus.csr_mtvec_i[1:0];
  assign trap_tgt = base;
`endif

  always_comb begin
    mst_trap        = bus.csr_mstatus_i;
    mst_trap[7]     = bus.csr_mstatus_i[3];
    mst_trap[3]     = 1'b0;
    mst_trap[12:11] = 2'b11;
    mst_mret        = bus.csr_mstatus_i;
    mst_mret[3]     = bus.csr_mstatus_i[7];
    mst_mret[7]     = 1'b1;
    mst_mret[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    cause_d               = cause_q;
    mret_d                = mret_q;
    bus.clint_csr_wen_o   = 1'b0;
    bus.clint_csr_waddr_o = '0;
    bus.clint_csr_wdata_o = '0;
    bus.stall_o           = 1'b1;
    bus.flush_o           = 1'b0;
    bus.redirect_valid_o  = 1'b0;
    bus.redirect_pc_o     = '0;

    unique case (state_q)
      IDLE: begin
        bus.stall_o = 1'b0;
        if (bus.ex_valid_i) begin
          if (irq || bus.ex_ecall_i) begin
            bus.stall_o = 1'b1;
            pc_d        = bus.ex_pc_i;
            cause_d     = irq ? CAUSE_MTI : CAUSE_ECALL;
            mret_d      = 1'b0;
            state_d     = W_MEPC;
          end else if (bus.ex_mret_i) begin
            bus.stall_o = 1'b1;
            mret_d      = 1'b1;
            state_d     = MRET_MST;
          end
        end
      end
      W_MEPC: begin
        if (!busy_cpu) begin
          bus.clint_csr_wen_o   = 1'b1;
          bus.clint_csr_waddr_o = ADDR_MEPC;
          bus.clint_csr_wdata_o = pc_q;
          state_d               = W_MCAUSE;
        end
      end
      W_MCAUSE: begin
        if (!busy_cpu) begin
          bus.clint_csr_wen_o   = 1'b1;
          bus.clint_csr_waddr_o = ADDR_MCAUSE;
          bus.clint_csr_wdata_o = cause_q;
          state_d               = W_MSTATUS;
        end
      end
      W_MSTATUS: begin
        if (!busy_cpu) begin
          bus.clint_csr_wen_o   = 1'b1;
          bus.clint_csr_waddr_o = ADDR_MSTATUS;
          bus.clint_csr_wdata_o = mst_trap;
          state_d               = JUMP;
        end
      end
      MRET_MST: begin
        if (!busy_cpu) begin
          bus.clint_csr_wen_o   = 1'b1;
          bus.clint_csr_waddr_o = ADDR_MSTATUS;
          bus.clint_csr_wdata_o = mst_mret;
          state_d               = JUMP;
        end
      end
      JUMP: begin
        bus.flush_o          = 1'b1;
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = mret_q ? bus.csr_mepc_i : trap_tgt;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle.
    if (!rst_n) begin
      bus.clint_csr_wen_o   = 1'b0;
      bus.clint_csr_waddr_o = '0;
      bus.clint_csr_wdata_o = '0;
      bus.stall_o           = 1'b0;
      bus.flush_o           = 1'b0;
      bus.redirect_valid_o  = 1'b0;
      bus.redirect_pc_o     = '0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a per-cycle reference model.
// The model tracks pending CSR writes and the redirect as a queue.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(64)) bus ();

  trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int OP_MEPC  = 0;
  localparam int OP_CAUSE = 1;
  localparam int OP_MST_T = 2;
  localparam int OP_MST_R = 3;
  localparam int OP_JMP   = 4;

  localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;

  int          ops[$];
  logic [63:0] m_pc, m_cause;
  logic        m_mret;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] f_mst_trap(logic [63:0] m);
    return (m & ~64'h1888) | (m[3] ? 64'h80 : 64'h0) | 64'h1800;
  endfunction

  function automatic logic [63:0] f_mst_mret(logic [63:0] m);
    return (m & ~64'h1888) | (m[7] ? 64'h8 : 64'h0) | 64'h1880;
  endfunction

  function automatic logic [63:0] f_trap_pc(logic [63:0] tv,
                                            logic [63:0] c);
    logic [63:0] b;
    b = tv & ~64'h3;
`ifdef TRAP_VECTORED_EN
    if (tv[1:0] == 2'b01 && c[63]) return b + 4 * (c & 64'h3f);
`endif
    return b;
  endfunction

  // Reference model and comparison, once per cycle on the falling edge.
  always @(negedge clk) begin
    logic        e_wen, e_stall, e_fl, e_rv, irq;
    logic [11:0] e_a;
    logic [63:0] e_d, e_pc;
    int          op;
    e_wen = 0; e_stall = 0; e_fl = 0; e_rv = 0;
    e_a = '0; e_d = '0; e_pc = '0;
    irq = bus.global_int_en_i & bus.mtime_int_en_i
        & bus.mtime_int_pend_i;
    if (!rst_n) begin
      ops.delete();
    end else if (ops.size() == 0) begin
      if (bus.ex_valid_i && (irq || bus.ex_ecall_i)) begin
        e_stall = 1;
        m_pc    = bus.ex_pc_i;
        m_cause = irq ? MTI : 64'd11;
        m_mret  = 0;
        ops = '{OP_MEPC, OP_CAUSE, OP_MST_T, OP_JMP};
      end else if (bus.ex_valid_i && bus.ex_mret_i) begin
        e_stall = 1;
        m_mret  = 1;
        ops = '{OP_MST_R, OP_JMP};
      end
    end else begin
      e_stall = 1;
      op = ops[0];
      if (op == OP_JMP) begin
        e_rv = 1; e_fl = 1;
        e_pc = m_mret ? bus.csr_mepc_i
                      : f_trap_pc(bus.csr_mtvec_i, m_cause);
        void'(ops.pop_front());
      end else if (!bus.cpu_csr_wen_i) begin
        e_wen = 1;
        case (op)
          OP_MEPC:  begin e_a = 12'h341; e_d = m_pc; end
          OP_CAUSE: begin e_a = 12'h342; e_d = m_cause; end
          OP_MST_T: begin
            e_a = 12'h300; e_d = f_mst_trap(bus.csr_mstatus_i);
          end
          default:  begin
            e_a = 12'h300; e_d = f_mst_mret(bus.csr_mstatus_i);
          end
        endcase
        void'(ops.pop_front());
      end
    end
    chk("m.wen", 64'(bus.clint_csr_wen_o), 64'(e_wen));
    chk("m.stall", 64'(bus.stall_o), 64'(e_stall));
    chk("m.flush", 64'(bus.flush_o), 64'(e_fl));
    chk("m.rv", 64'(bus.redirect_valid_o), 64'(e_rv));
    if (e_wen || !rst_n) begin
      chk("m.waddr", 64'(bus.clint_csr_waddr_o), 64'(e_a));
      chk("m.wdata", bus.clint_csr_wdata_o, e_d);
    end
    if (e_rv || !rst_n) chk("m.rpc", bus.redirect_pc_o, e_pc);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ex_valid_i    = 0;
    bus.ex_ecall_i    = 0;
    bus.ex_mret_i     = 0;
    bus.cpu_csr_wen_i = 0;
  endtask

  task automatic fire(logic ec, logic mr, logic [63:0] pc);
    bus.ex_valid_i = 1;
    bus.ex_ecall_i = ec;
    bus.ex_mret_i  = mr;
    bus.ex_pc_i    = pc;
    @(negedge clk);
    chk("detect stall", 64'(bus.stall_o), 64'd1);
    nxt();
    idle_in();
  endtask

  task automatic w_at(string nm, logic [11:0] a, logic [63:0] d);
    @(negedge clk);
    chk({nm, " wen"}, 64'(bus.clint_csr_wen_o), 64'd1);
    chk({nm, " addr"}, 64'(bus.clint_csr_waddr_o), 64'(a));
    chk({nm, " data"}, bus.clint_csr_wdata_o, d);
    nxt();
  endtask

  task automatic j_at(string nm, logic [63:0] pc);
    @(negedge clk);
    chk({nm, " rv"}, 64'(bus.redirect_valid_o), 64'd1);
    chk({nm, " flush"}, 64'(bus.flush_o), 64'd1);
    chk({nm, " pc"}, bus.redirect_pc_o, pc);
    nxt();
    @(negedge clk);
    chk({nm, " idle"}, 64'(bus.stall_o), 64'd0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] vec_exp;
    idle_in();
    bus.ex_pc_i          = '0;
    bus.global_int_en_i  = 0;
    bus.mtime_int_en_i   = 0;
    bus.mtime_int_pend_i = 0;
    bus.csr_mtvec_i      = 64'h8000_0000;
    bus.csr_mepc_i       = '0;
    bus.csr_mstatus_i    = 64'h1808;
    #1;
    nxt();
    @(negedge clk);
    chk("reset stall", 64'(bus.stall_o), 64'd0);
    chk("reset wen", 64'(bus.clint_csr_wen_o), 64'd0);
    chk("reset rv", 64'(bus.redirect_valid_o), 64'd0);
    nxt();
    rst_n = 1;
    nxt();

    // ecall
    fire(1, 0, 64'h8000_0100);
    w_at("t1 mepc", 12'h341, 64'h8000_0100);
    w_at("t1 mcause", 12'h342, 64'd11);
    w_at("t1 mstatus", 12'h300, 64'h1880);
    j_at("t1 jump", 64'h8000_0000);

    // mret
    bus.csr_mstatus_i = 64'h1880;
    bus.csr_mepc_i    = 64'h8000_0104;
    fire(0, 1, 64'h8000_0104);
    w_at("t2 mstatus", 12'h300, 64'h1888);
    j_at("t2 jump", 64'h8000_0104);

    // timer irq wins over ecall, then MIE=0 lets ecall through
    bus.csr_mstatus_i    = 64'h1808;
    bus.global_int_en_i  = 1;
    bus.mtime_int_en_i   = 1;
    bus.mtime_int_pend_i = 1;
    fire(1, 0, 64'h8000_0200);
    w_at("t3 mepc", 12'h341, 64'h8000_0200);
    w_at("t3 mcause", 12'h342, MTI);
    w_at("t3 mstatus", 12'h300, 64'h1880);
    j_at("t3 jump", 64'h8000_0000);
    bus.global_int_en_i = 0;
    fire(1, 0, 64'h8000_0200);
    w_at("t3b mepc", 12'h341, 64'h8000_0200);
    w_at("t3b mcause", 12'h342, 64'd11);
    w_at("t3b mstatus", 12'h300, 64'h1880);
    j_at("t3b jump", 64'h8000_0000);
    bus.mtime_int_pend_i = 0;

    // CPU write collides with the mcause write
    fire(1, 0, 64'h8000_0300);
    w_at("t4 mepc", 12'h341, 64'h8000_0300);
    bus.cpu_csr_wen_i = 1;
    @(negedge clk);
    chk("t4 held wen", 64'(bus.clint_csr_wen_o), 64'd0);
    chk("t4 held stall", 64'(bus.stall_o), 64'd1);
    nxt();
    bus.cpu_csr_wen_i = 0;
    w_at("t4 mcause", 12'h342, 64'd11);
    w_at("t4 mstatus", 12'h300, 64'h1880);
    j_at("t4 jump", 64'h8000_0000);

    // vectored mode
`ifdef TRAP_VECTORED_EN
    vec_exp = 64'h8000_001C;
`else
    vec_exp = 64'h8000_0000;
`endif
    bus.csr_mtvec_i      = 64'h8000_0001;
    bus.global_int_en_i  = 1;
    bus.mtime_int_pend_i = 1;
    fire(0, 0, 64'h8000_0400);
    repeat (3) nxt();
    j_at("t5 irq jump", vec_exp);
    bus.global_int_en_i  = 0;
    bus.mtime_int_pend_i = 0;
    fire(1, 0, 64'h8000_0404);
    repeat (3) nxt();
    j_at("t5 ecall jump", 64'h8000_0000);
    bus.csr_mtvec_i = 64'h8000_0000;

    // reset in the middle of a trap sequence
    fire(1, 0, 64'h8000_0500);
    w_at("t6 mepc", 12'h341, 64'h8000_0500);
    rst_n = 0;
    nxt();
    rst_n = 1;
    @(negedge clk);
    chk("t6 stall", 64'(bus.stall_o), 64'd0);
    chk("t6 wen", 64'(bus.clint_csr_wen_o), 64'd0);
    chk("t6 rv", 64'(bus.redirect_valid_o), 64'd0);
    chk("t6 flush", 64'(bus.flush_o), 64'd0);
    repeat (4) nxt();

    // mret after the aborted sequence still works
    bus.csr_mstatus_i = 64'h0080;
    bus.csr_mepc_i    = 64'h8000_0600;
    fire(0, 1, 64'h8000_0600);
    w_at("t7 mstatus", 12'h300, 64'h1888);
    j_at("t7 jump", 64'h8000_0600);

    repeat (2) nxt();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
